// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
// The requester drives the op and operands; the unit returns status and result.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes at acceptance. An unsigned core then runs
// 32 shift-add or restoring-divide steps, and the sign fix-up is applied as the
// result is written. Divide-by-zero and signed overflow skip iteration entirely.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

  state_t              state_q, state_d;
  muldiv_funct3_t      op_in, op_q;
  logic                accept, special, div_zero, div_ovf;
  logic                a_neg_in, b_neg_in, a_neg_q, b_neg_q;
  logic [XLEN-1:0]     a_mag_in, b_mag_in, b_mag_q, special_res;
  logic [2*XLEN-1:0]   acc_q, acc_nxt, prod;
  logic [XLEN-1:0]     rem_q, rem_nxt, quot, rmd, calc_res, result_q;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [CNT_W-1:0]    cnt_q;

  assign op_in  = muldiv_funct3_t'(bus.funct3);
  assign accept = (state_q == IDLE) && bus.start && !bus.flush;

  // Decode the incoming request: signedness, magnitudes and special cases.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so that
    // no path leaves it unassigned and a latch is inferred.
    special_res = '0;
    a_neg_in    = bus.rs1_data[XLEN-1] && (op_in inside {MUL, MULH, MULHSU, DIV, REM});
    b_neg_in    = bus.rs2_data[XLEN-1] && (op_in inside {MUL, MULH, DIV, REM});
    a_mag_in    = a_neg_in ? -bus.rs1_data : bus.rs1_data;
    b_mag_in    = b_neg_in ? -bus.rs2_data : bus.rs2_data;
    div_zero    = op_in[2] && (bus.rs2_data == '0);
    div_ovf     = ((op_in == DIV) || (op_in == REM)) &&
                  (bus.rs1_data == SMIN) && (bus.rs2_data == '1);
    special     = div_zero || div_ovf;
    // op_in[1] separates the remainder ops from the quotient ops.
    if (div_zero)     special_res = op_in[1] ? bus.rs1_data : '1;
    else if (div_ovf) special_res = op_in[1] ? '0 : SMIN;
  end

  // One iteration of the unsigned core plus the signed result it would produce.
  always_comb begin
    // Multiply: multiplier sits in acc[XLEN-1:0] and is consumed LSB first while
    // the partial product grows into the upper half.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    // Divide: dividend bits leave acc[XLEN-1] MSB first and quotient bits enter
    // at the bottom. The trial subtraction is one bit wider so its top bit is
    // the borrow; the partial remainder itself always fits back into XLEN bits.
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    if (op_q[2]) begin
      rem_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      acc_nxt = {{XLEN{1'b0}}, acc_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      rem_nxt = rem_q;
      acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod = (a_neg_q ^ b_neg_q) ? -acc_nxt : acc_nxt;
    quot = (a_neg_q ^ b_neg_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rmd  = a_neg_q ? -rem_nxt : rem_nxt;
    case (op_q)
      MUL:                 calc_res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: calc_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           calc_res = quot;
      default:             calc_res = rmd;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state is updated with non-blocking assignments so that all
    // registers sample the pre-edge values regardless of statement order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE and beats a new start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? FIN : CALC;
      CALC: if (bus.flush)         state_d = IDLE;
            else if (cnt_q == LAST) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs; a flush in the FIN cycle suppresses that done pulse.
  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == FIN) && !bus.flush;
    bus.result = result_q;
  end

  // Operand latch, iteration registers and result write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      a_neg_q <= a_neg_in;
      b_neg_q <= b_neg_in;
      b_mag_q <= b_mag_in;
      acc_q   <= {{XLEN{1'b0}}, a_mag_in};
      rem_q   <= '0;
      cnt_q   <= '0;
      if (special) result_q <= special_res;
    end else if ((state_q == CALC) && !bus.flush) begin
      acc_q <= acc_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) result_q <= calc_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written flush/reset sequences.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit / 32-bit arithmetic straight from the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          si, sj;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    si = $signed(a);
    sj = $signed(b);
    p  = '0;
    case (f3)
      F_MUL:    begin p = sa * sb; return p[31:0];  end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * ub; return p[63:32]; end
      F_MULHU:  begin p = ua * ub; return p[63:32]; end
      F_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                else if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
                else return 32'(si / sj);
      F_DIVU:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      F_REM:    if (b == 0) return a;
                else if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
                else return 32'(si % sj);
      default:  if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == SMIN && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Issue one op at the current negedge and wait (bounded) for done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n);
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.funct3   = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    res    = 'x;
    lat    = 0;
    busy_n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = i;
        res = bus.result;
        break;
      end
    end
  endtask

  vec_t        tbl[14];
  logic [31:0] res, exp;
  int          lat, busy_n, dones;

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0;

    tbl[0]  = '{F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{F_MULH,   SMIN,         SMIN,          32'h4000_0000, 33};
    tbl[2]  = '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[3]  = '{F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{F_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33};
    tbl[5]  = '{F_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};
    tbl[6]  = '{F_DIVU,   32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 33};
    tbl[7]  = '{F_REMU,   32'hFFFF_FFF9, 32'd2,        32'd1,         33};
    tbl[8]  = '{F_DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, 1};
    tbl[9]  = '{F_DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, 1};
    tbl[10] = '{F_REM,    32'd5,        32'd0,         32'd5,         1};
    tbl[11] = '{F_REMU,   32'd5,        32'd0,         32'd5,         1};
    tbl[12] = '{F_DIV,    SMIN,         32'hFFFF_FFFF, SMIN,          1};
    tbl[13] = '{F_REM,    SMIN,         32'hFFFF_FFFF, 32'd0,         1};

    // Reset state.
    #12;
    check("reset_busy",   bus.busy,   0);
    check("reset_done",   bus.done,   0);
    check("reset_result", bus.result, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors.
    foreach (tbl[i]) begin
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, res, lat, busy_n);
      check($sformatf("vec%0d_result", i), res, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, tbl[i].lat);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {bus.done, bus.busy}, 0);
    end

    // Randomized ops with occasional boundary operands.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = SMIN; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))); end
        default: ;
      endcase
      run_op(f3, a, b, res, lat, busy_n);
      check($sformatf("rand%0d_f%0d_%h_%h", n, f3, a, b), res, model(f3, a, b));
      check($sformatf("rand%0d_latency", n), lat, model_lat(f3, a, b));
      @(negedge clk);
    end

    // Flush mid-CALC: no done, result keeps prior value, next start is normal.
    run_op(F_MUL, 32'd6, 32'd7, res, lat, busy_n);
    check("pre_flush_result", res, 32'd42);
    @(negedge clk);
    bus.funct3 = F_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd5; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy",   bus.busy,   0);
    check("flush_done",   bus.done | (dones != 0), 0);
    check("flush_result", bus.result, 32'd42);
    run_op(F_DIVU, 32'd100, 32'd7, res, lat, busy_n);
    check("after_flush_result",  res, 32'd14);
    check("after_flush_latency", lat, 33);
    @(negedge clk);

    // Start pulsed while busy is ignored and not queued.
    bus.funct3 = F_MUL; bus.rs1_data = 32'd9; bus.rs2_data = 32'd11; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    res = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.funct3 = F_DIV; bus.rs1_data = 32'd100; bus.rs2_data = 32'd0; bus.start = 1'b1;
      end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        res = bus.result;
        break;
      end
    end
    check("busy_start_result",  res, 32'd99);
    check("busy_start_latency", lat, 33);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("busy_start_not_queued", dones, 0);

    // Flush and start in the same IDLE cycle: flush wins.
    bus.funct3 = F_REMU; bus.rs1_data = 32'd9; bus.rs2_data = 32'd0;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    @(negedge clk);
    check("flush_start_busy",   bus.busy,   0);
    check("flush_start_done",   bus.done,   0);
    check("flush_start_result", bus.result, 32'd99);

    // Flush in the FIN cycle suppresses done.
    bus.funct3 = F_DIV; bus.rs1_data = 32'd5; bus.rs2_data = 32'd0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("fin_done_before_flush", bus.done, 1);
    bus.flush = 1'b1;
    #1 check("fin_flush_done", bus.done, 0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("fin_flush_busy", bus.busy, 0);

    // Asynchronous reset mid-CALC.
    bus.funct3 = F_MUL; bus.rs1_data = 32'h1234; bus.rs2_data = 32'h5678; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy",   bus.busy,   0);
    check("async_rst_done",   bus.done,   0);
    check("async_rst_result", bus.result, 0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("post_reset_no_done", dones, 0);
    run_op(F_REM, 32'hFFFF_FFF9, 32'd2, res, lat, busy_n);
    check("post_reset_result",  res, 32'hFFFF_FFFF);
    check("post_reset_latency", lat, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execute unit. It consumes the muldiv_funct3_t op encoding and the two register operands issued alongside the integer ALU. It produces a 32-bit result for writeback. Multi-cycle: the pipeline stalls on busy until done pulses.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when busy=0 and flush=0
funct3  input  3  muldiv_funct3_t: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
rs1_data  input  32  operand A (multiplicand / dividend)
rs2_data  input  32  operand B (multiplier / divisor)
flush  input  1  abort the in-flight op (branch mispredict / trap)
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse; result valid in this cycle
result  output  32  op result; held stable until the next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0. This takes effect immediately, mid-operation included. No done follows reset release.
- States: IDLE, CALC, FIN.
  - IDLE -> CALC when start&!flush and the op is not a special case.
  - IDLE -> FIN when start&!flush and the op is a special case.
  - CALC -> FIN when counter==XLEN-1 on the final iteration edge.
  - FIN -> IDLE unconditionally.
- done=1 only in FIN. busy=1 in CALC and FIN.
- Latency, with start sampled at edge E0:
  - Normal ops: done high in the cycle after edge E33, so exactly 33 cycles (32 iterations + FIN).
  - Special cases: done high in the cycle after E1.
- Operand latch at acceptance: op, sign flags and operand magnitudes.
  - Signedness: mul/mulh/div/rem treat both operands as signed. mulhsu treats A signed, B unsigned. mulhu/divu/remu treat both as unsigned.
  - The unsigned core works on |A| and |B|.
- Multiply: radix-2 shift-add, one multiplier bit per cycle, 64-bit accumulator. Final sign fix: negate the 64-bit product if sign(A) XOR sign(B), considering signed operands only.
  - mul returns product[31:0].
  - mulh/mulhsu/mulhu return product[63:32].
- Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved without iteration:
  - B==0: div/divu return 0xFFFFFFFF; rem/remu return A unchanged.
  - Signed overflow (div/rem with A=0x80000000, B=0xFFFFFFFF): div returns 0x80000000; rem returns 0.
  - Multiply has no special cases.
- result is written on the edge entering FIN and held through IDLE until the next FIN write.
- start while busy=1 is ignored; no queuing. The requester holds start and re-presents it.
- start on the FIN cycle is ignored because busy=1. It is accepted on the following IDLE cycle.
- flush in CALC or FIN: next edge -> IDLE, busy=0, done suppressed, result unchanged.
- flush and start in the same IDLE cycle: flush wins and the op is not accepted.
- Operand or funct3 changes after acceptance have no effect.

Test Plan:
- Multiply, mul: A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB. done exactly 33 cycles after start; busy high for 33 cycles; single-cycle done pulse.
- High multiply:
  - mulh 0x80000000 x 0x80000000 -> 0x40000000.
  - mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide:
  - div -7/2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF.
  - divu 0xFFFFFFF9/2 -> 0x7FFFFFFC; remu -> 1.
- Special cases, each with done 1 cycle after start:
  - A=5, B=0: div and divu -> 0xFFFFFFFF; rem and remu -> 5.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0.
- Flush and start collisions:
  - Start mul; assert flush 10 cycles later -> busy=0 next cycle, no done, result keeps prior value.
  - A new start on the following cycle completes normally.
  - A start pulsed while busy is ignored.
- Reset: drive rst=0 asynchronously mid-CALC (between edges) -> busy, done and result read 0 before the next clk edge. After release, no done until a new start.
